// File: rtl/uart_rx_vote.sv
// uart_rx_vote: 8N1 UART receiver with input synchroniser, 3-sample majority
// vote at each bit centre, false-start rejection, framing-error and break
// detection. Rx_DV / Frame_Err / Parity_Err are one-cycle pulses, Rx_Byte holds
// the last good byte, Break_Det is a level.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with a Parity_Err
// output that pulses together with Rx_DV (the byte is still delivered).
module uart_rx_vote #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd10417,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx_Serial,
    output logic       Rx_DV,
    output logic [7:0] Rx_Byte,
    output logic       Frame_Err,
    output logic       Break_Det,
`ifdef UART_RX_PARITY_EN
    output logic       Parity_Err,
`endif
    output logic       Busy
);

    localparam logic [15:0] HALF = CLKS_PER_BIT >> 1;
    localparam logic [15:0] H_M1 = HALF - 16'd1;
    localparam logic [15:0] H_P1 = HALF + 16'd1;
    localparam logic [15:0] LAST = CLKS_PER_BIT - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HI
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_adv;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        fe_q, fe_d;
    logic        brk_q, brk_d;
    logic        hi_q, hi_d;
    logic [1:0]  samp_q;
    logic        vote, vote_now;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        pe_q, pe_d;
`endif

    // Synchroniser: flops reset to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], Rx_Serial};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Capture the first two of the three centre samples; the third is s itself at cnt = H+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= 2'b11;
        end else begin
            if (cnt_q == H_M1) samp_q[0] <= s;
            if (cnt_q == HALF) samp_q[1] <= s;
        end
    end

    assign vote_now = (cnt_q == H_P1);
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & s) | (samp_q[1] & s);
    assign cnt_adv  = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;

    // Frame FSM: next-state, counters, shift register and output pulses.
    always_comb begin
        // NOTE: every signal gets its hold/default value first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        brk_d     = brk_q;
        hi_d      = hi_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        pe_d      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                hi_d  = 1'b0;
                // The cycle s first reads low is cycle 0 of the start bit.
                if (!s) begin
                    state_d = S_START;
                    cnt_d   = 16'd1;
                end
            end
            S_START: begin
                cnt_d = cnt_adv;
                if (vote_now) begin
                    if (vote) begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt_adv;
                if (vote_now) begin
                    shift_d = {vote, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_adv;
                if (vote_now) begin
                    par_d   = vote;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_d = cnt_adv;
                if (vote_now) begin
                    cnt_d = 16'd0;
                    if (vote) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        pe_d    = ^{shift_q, par_q};
`endif
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        if (shift_q == 8'h00) brk_d = 1'b1;
                        state_d = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                cnt_d = 16'd0;
                // Two consecutive high samples are needed so a break cannot re-trigger a frame.
                if (s) begin
                    if (hi_q) begin
                        state_d = S_IDLE;
                        brk_d   = 1'b0;
                        hi_d    = 1'b0;
                    end else begin
                        hi_d = 1'b1;
                    end
                end else begin
                    hi_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            brk_q     <= 1'b0;
            hi_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
            brk_q     <= brk_d;
            hi_q      <= hi_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            pe_q      <= pe_d;
`endif
        end
    end

    assign Rx_DV     = dv_q;
    assign Rx_Byte   = byte_q;
    assign Frame_Err = fe_q;
    assign Break_Det = brk_q;
    assign Busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign Parity_Err = pe_q;
`endif

endmodule
